ex_stage: RTL
=============

# ex_stage

Execute stage of the five-stage in-order core, between ID and MEM. Holds one instruction in a pipeline register, computes its integer result (single-cycle ALU ops and a multi-cycle iterative divider), checks load/store alignment, and issues the data SRAM request. Drives the valid/allowin handshake and the EX→MEM bus consumed by the MEM stage.

## Interface
- PAY_W, 160: width of the opaque sideband payload (pc, inst, dest, gr_we, CSR fields, exception fields), carried unchanged ID→MEM.
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- id_ex_valid  in  1  ID holds a valid instruction
- ex_allowin  out  1  EX accepts a new instruction this cycle
- id_ex_bus  in  PAY_W+105  {payload, op[3:0], src1[31:0], src2[31:0], st_data[31:0], mem_re, mem_we, mem_type[2:0]}
- ex_mem_valid  out  1  EX presents a finished instruction to MEM
- mem_allowin  in  1  MEM accepts this cycle
- ex_mem_bus  out  PAY_W+39  {payload, result[31:0], mem_type[2:0], addr_low2[1:0], res_from_mem, ale}
- data_sram_en  out  1  memory request strobe
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  request address
- data_sram_wdata  out  32  store data, lane-replicated
- mem_ex  in  1  MEM holds an excepting instruction
- wb_ex  in  1  WB exception flush
- ertn_flush  in  1  WB ertn flush

## Operation
- op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 NOR, 8 DIV, 9 DIVU, 10 MOD, 11 MODU; 12-15 produce result 0.
- Loads/stores use op ADD; address = src1+src2 (mod 2^32); addr_low2 = address[1:0]; res_from_mem = mem_re.
- mem_type[1:0]: 00 word, 01 half, 10 byte; bit2 = zero-extend (loads only).
- ale = (mem_re|mem_we) & ((half & addr[0]) | (word & addr[1:0]!=0)).
- Store lanes: byte → we = 1<<addr[1:0], wdata = {4{st_data[7:0]}}; half → we = addr[1]?1100:0011, wdata = {2{st_data[15:0]}}; word → 1111, st_data.
- Request issue: data_sram_en = ex_valid & ex_ready_go & mem_allowin & (mem_re|mem_we) & ~ale & ~mem_ex & ~wb_ex & ~ertn_flush; data_sram_we = en & mem_we ? lanes : 0. Exactly one request per instruction.
- Divider FSM (32-bit restoring, radix-2, on magnitudes; signs fixed at end):
  - IDLE: div op valid in EX and not yet done → load operands, count=0, go BUSY.
  - BUSY: one quotient bit per cycle; count reaching 31 → DONE.
  - DONE: result latched, ex_ready_go=1; on EX→MEM handoff → IDLE.
- Quotient sign = src1 sign XOR src2 sign (signed ops); remainder sign = src1 sign.
- Divide by zero: quotient 0xFFFFFFFF, remainder = src1. Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Flush: wb_ex or ertn_flush clears ex_valid and forces divider to IDLE on the same edge; no request issued that cycle.

## Timing
- Reset: ex_valid=0, FSM=IDLE, ex_mem_valid=0, ex_allowin=1, data_sram_en=0, data_sram_we=0; pipeline register contents don't-care.
- ex_ready_go = 1 for non-div ops; for div ops only in DONE.
- ex_mem_valid = ex_valid & ex_ready_go & ~wb_ex & ~ertn_flush.
- ex_allowin = ~ex_valid | (ex_ready_go & mem_allowin).
- ex_valid <= ex_allowin ? id_ex_valid : ex_valid; bus register loads when id_ex_valid & ex_allowin.
- Non-div latency: 1 cycle in EX. Div latency: accepted at edge N, IDLE→BUSY at N+1, DONE at N+33, handoff at earliest N+33 if mem_allowin.
- DONE with mem_allowin=0: result and FSM held until accepted.
- Back-to-back divs: second div starts only after first leaves EX.

## Configuration
- EX_DIV_EN defined: divider FSM and ops 8-11 as above.
- EX_DIV_EN undefined: no divider logic; ops 8-11 return 0 with ex_ready_go=1 (single-cycle).

## Test plan
- ADD src1=0x7FFFFFFF, src2=1, mem_allowin=1 → next cycle ex_mem_valid=1, result=0x80000000; SLT same operands → result 0.
- Store byte src1=0x1000, src2=3, st_data=0xAB → data_sram_en=1, we=1000, addr=0x1003, wdata=0xABABABAB, exactly one cycle.
- Load word address 0x1002 → ale=1, data_sram_en never asserts, ex_mem_valid=1 with ale=1.
- DIV src1=-7, src2=2 → ex_allowin=0 for 33 cycles, result 0xFFFFFFFD; MOD same → 0xFFFFFFFF; DIVU 5/0 → 0xFFFFFFFF; MODU 5/0 → 5.
- wb_ex pulse at BUSY cycle 10 → ex_valid=0 next edge, FSM IDLE, ex_allowin=1, no ex_mem_valid.
- reset asserted mid-div with mem_allowin=0 → outputs immediately at reset values; new ADD after release completes in 1 cycle.

Source files
------------

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - EX stage: ALU, LSU request issue, optional iterative divider (EX_DIV_EN)
// Divider present only when EX_DIV_EN is defined; otherwise ops 8-11 return 0 in one cycle.
module ex_stage #(
  parameter int PAY_W = 160
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_ex_valid,
  output logic               ex_allowin,
  input  logic [PAY_W+104:0] id_ex_bus,
  output logic               ex_mem_valid,
  input  logic               mem_allowin,
  output logic [PAY_W+38:0]  ex_mem_bus,
  output logic               data_sram_en,
  output logic [3:0]         data_sram_we,
  output logic [31:0]        data_sram_addr,
  output logic [31:0]        data_sram_wdata,
  input  logic               mem_ex,
  input  logic               wb_ex,
  input  logic               ertn_flush
);
  logic               ex_valid;
  logic [PAY_W+104:0] bus_r;
  logic [PAY_W-1:0]   payload;
  logic [3:0]         op;
  logic [31:0]        src1, src2, st_data;
  logic               mem_re, mem_we;
  logic [2:0]         mem_type;

  assign {payload, op, src1, src2, st_data, mem_re, mem_we, mem_type} = bus_r;

  logic        flush, ex_ready_go, ale, is_word, is_half;
  logic [31:0] addr, alu_res, result, lane_data;
  logic [3:0]  lanes;

  assign flush = wb_ex | ertn_flush;
  assign addr  = src1 + src2;

  always_comb begin
    alu_res = 32'd0;
    case (op)
      4'd0:    alu_res = addr;
      4'd1:    alu_res = src1 - src2;
      4'd2:    alu_res = src1 & src2;
      4'd3:    alu_res = src1 | src2;
      4'd4:    alu_res = src1 ^ src2;
      4'd5:    alu_res = {31'd0, $signed(src1) < $signed(src2)};
      4'd6:    alu_res = {31'd0, src1 < src2};
      4'd7:    alu_res = ~(src1 | src2);
      default: alu_res = 32'd0;
    endcase
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
  div_state_t  state, state_nx;
  logic        is_div, div_signed, want_rem, q_neg, r_neg, ge;
  logic [31:0] dvd, dvs, rem, quo, div_res, abs1, abs2;
  logic [31:0] diff, rem_nx, quo_nx, q_fin, r_fin;
  logic [32:0] tmp;
  logic [4:0]  cnt;

  assign is_div     = (op[3:2] == 2'b10);
  assign div_signed = ~op[0];
  assign want_rem   = op[1];
  assign q_neg      = div_signed & (src1[31] ^ src2[31]);
  assign r_neg      = div_signed & src1[31];
  assign abs1       = (div_signed & src1[31]) ? -src1 : src1;
  assign abs2       = (div_signed & src2[31]) ? -src2 : src2;

  // Restoring step: the difference fits 32 bits whenever it is kept
  assign tmp    = {rem, dvd[31]};
  assign ge     = tmp >= {1'b0, dvs};
  assign diff   = tmp[31:0] - dvs;
  assign rem_nx = ge ? diff : tmp[31:0];
  assign quo_nx = {quo[30:0], ge};
  assign q_fin  = (dvs == 32'd0) ? 32'hFFFF_FFFF : (q_neg ? -quo_nx : quo_nx);
  assign r_fin  = (dvs == 32'd0) ? src1 : (r_neg ? -rem_nx : rem_nx);

  always_comb begin
    state_nx = state;
    case (state)
      DIV_IDLE: if (ex_valid & is_div & ~flush) state_nx = DIV_BUSY;
      DIV_BUSY: if (flush) state_nx = DIV_IDLE;
                else if (cnt == 5'd31) state_nx = DIV_DONE;
      DIV_DONE: if (flush | mem_allowin) state_nx = DIV_IDLE;
      default:  state_nx = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (state == DIV_IDLE) begin
      dvd <= abs1;
      dvs <= abs2;
      rem <= 32'd0;
      quo <= 32'd0;
      cnt <= 5'd0;
    end else if (state == DIV_BUSY) begin
      dvd <= {dvd[30:0], 1'b0};
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) div_res <= want_rem ? r_fin : q_fin;
    end
  end

  assign ex_ready_go = ~is_div | (state == DIV_DONE);
  assign result      = is_div ? div_res : alu_res;
`else
  assign ex_ready_go = 1'b1;
  assign result      = alu_res;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           ex_valid <= 1'b0;
    else if (flush)      ex_valid <= 1'b0;
    else if (ex_allowin) ex_valid <= id_ex_valid;
  end

  always_ff @(posedge clk) begin
    if (id_ex_valid & ex_allowin) bus_r <= id_ex_bus;
  end

  assign ex_allowin   = ~ex_valid | (ex_ready_go & mem_allowin);
  assign ex_mem_valid = ex_valid & ex_ready_go & ~flush;

  assign is_word = (mem_type[1:0] == 2'b00);
  assign is_half = (mem_type[1:0] == 2'b01);
  assign ale     = (mem_re | mem_we) & ((is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00)));

  always_comb begin
    lanes     = 4'b1111;
    lane_data = st_data;
    case (mem_type[1:0])
      2'b10: begin
        lanes     = 4'b0001 << addr[1:0];
        lane_data = {4{st_data[7:0]}};
      end
      2'b01: begin
        lanes     = addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{st_data[15:0]}};
      end
      default: begin
        lanes     = 4'b1111;
        lane_data = st_data;
      end
    endcase
  end

  // A request fires only on the handoff cycle, so each instruction issues once
  assign data_sram_en    = ex_valid & ex_ready_go & mem_allowin & (mem_re | mem_we)
                         & ~ale & ~mem_ex & ~flush;
  assign data_sram_we    = (data_sram_en & mem_we) ? lanes : 4'b0000;
  assign data_sram_addr  = addr;
  assign data_sram_wdata = lane_data;
  assign ex_mem_bus      = {payload, result, mem_type, addr[1:0], mem_re, ale};
endmodule
